effect_mode_ctrl: RTL and testbench
===================================

// Module: effect_mode_ctrl
// PURPOSE
//  Sequences effect selection for the audio data processor. Takes a raw push-button and a register-style
//  config port, then drives the one-hot-or-zero effect enables (dist/delay/iir) into the processor.
//  Mode changes apply only on sample boundaries, inside a mute window, so switching does not click.
//  Sits between board I/O / control bus and the data processor; mute gates DAC-FIFO data downstream.
// PARAMETERS
//  DEBOUNCE_CYCLES  16'd50000  consecutive stable clk cycles before button level accepted (1 ms @ 50 MHz)
//  DB_W             16         width of debounce counter
//  MUTE_SAMPLES     64         samples muted before AND after a mode change (>=1)
//  MS_W             7          width of mute sample counter (must hold MUTE_SAMPLES-1)
// PORTS
//  clk           in   1  system clock
//  rst           in   1  reset, asynchronous, active-high
//  btn_next      in   1  raw async push-button, active-high; press = advance to next mode
//  cfg_valid     in   1  config request valid
//  cfg_mode      in   2  requested mode (0 bypass, 1 dist, 2 delay, 3 iir)
//  cfg_ready     out  1  config request accepted when cfg_valid && cfg_ready
//  sample_strobe in   1  one-cycle pulse per sample written to DAC FIFO (wr_dac of processor)
//  effect_dist   out  1  distortion enable
//  effect_delay  out  1  delay enable
//  effect_iir    out  1  echo/iir enable
//  mode          out  2  current applied mode
//  mute          out  1  1 = downstream forces DAC samples to zero
//  busy          out  1  1 = mode change in progress
// BEHAVIOUR
//  Reset (async): state RUN, mode=0, all effect_* =0, mute=0, busy=0, cfg_ready=1, debouncer cleared (level 0).
//  Debounce: 2-FF sync of btn_next; counter restarts on any change of synced level vs debounced level;
//   debounced level updates after DEBOUNCE_CYCLES equal samples. Rising edge of debounced level -> 1-cycle btn_req.
//   Latency press->btn_req: 2 + DEBOUNCE_CYCLES (+1) cycles. Bounce shorter than DEBOUNCE_CYCLES -> no req.
//  Effect outputs: registered decode of mode; 0->none, 1->dist, 2->delay, 3->iir; never more than one high.
//  cfg_ready = (state==RUN), combinational from state.
//  FSM:
//   RUN: if cfg_valid (accepted): if cfg_mode==mode -> accepted, no-op, stay RUN; else target<=cfg_mode -> MUTE_OUT.
//        else if btn_req: target<=mode+1 (3 wraps to 0) -> MUTE_OUT.  cfg has priority when same cycle; btn_req dropped.
//        Entering MUTE_OUT: mute=1, busy=1 from next cycle; cnt<=0.
//   MUTE_OUT: each sample_strobe increments cnt; on strobe with cnt==MUTE_SAMPLES-1: mode<=target, cnt<=0 -> MUTE_IN.
//   MUTE_IN: same count; on strobe with cnt==MUTE_SAMPLES-1 -> RUN; mute=0, busy=0 next cycle.
//  btn_req and cfg_valid in MUTE_OUT/MUTE_IN are ignored (button dropped, cfg held off by cfg_ready=0).
//  No sample_strobe (FIFO stalled): FSM waits indefinitely, mute held.
//  Mode changes exactly once per transition, at MUTE_OUT->MUTE_IN edge; effect_* follow one cycle later (still muted).
//  Reset mid-transition: immediate return to reset state; pending target discarded.
// STRUCTURE
//  Package audio_fx_pkg: MODE_BYPASS/DIST/DELAY/IIR (2-bit localparams), FSM state encodings RUN/MUTE_OUT/MUTE_IN.
//  Sub-module btn_debounce (sync + counter + edge pulse), params DEBOUNCE_CYCLES, DB_W; output btn_req.
//  Top holds FSM, mute counter, target/mode regs, output decode.
// TESTING  (bench params: DEBOUNCE_CYCLES=4, MUTE_SAMPLES=4, strobe every 8 clk)
//  Reset release -> mode=0, effect_*=000, mute=0, cfg_ready=1; assert rst mid-MUTE_IN -> same values at once.
//  Clean press held 10 clk -> one btn_req; mute=1; after 4 strobes mode=1, effect_dist=1; after 4 more mute=0.
//  Bouncy press (toggle every 2 clk for 12 clk, then stable) -> exactly one mode advance; 3 presses from 0 -> mode 3, 4th -> 0.
//  cfg_valid, cfg_mode=2 in RUN -> accepted same cycle, after 4 strobes effect_delay=1 only; cfg_mode==mode -> no mute.
//  cfg_valid + btn_req same cycle, cfg_mode=3 -> mode 3 (button dropped); cfg_valid during mute -> cfg_ready=0, held until RUN.
//  Strobes stopped during MUTE_OUT for 200 clk -> mode unchanged, mute stays 1; resume -> completes after remaining strobes.

Source files
------------

// File: rtl/audio_fx_pkg.sv
//------------------------------------------------------------------------------
// audio_fx_pkg : shared mode codes, sequencer state encodings, mode decode
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package audio_fx_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_DIST   = 2'd1;
  localparam logic [1:0] MODE_DELAY  = 2'd2;
  localparam logic [1:0] MODE_IIR    = 2'd3;

  localparam int         ST_W        = 2;
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MUTE_OUT = 2'd1;
  localparam logic [1:0] ST_MUTE_IN  = 2'd2;

  // Returns {iir, delay, dist}; at most one bit set.
  function automatic logic [2:0] mode_to_fx(input logic [1:0] mode);
    logic [2:0] fx;
    case (mode)
      MODE_DIST:  fx = 3'b001;
      MODE_DELAY: fx = 3'b010;
      MODE_IIR:   fx = 3'b100;
      default:    fx = 3'b000;
    endcase
    return fx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
//------------------------------------------------------------------------------
// btn_debounce : 2-FF synchroniser, stability counter, rising-edge request pulse
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int          DB_W            = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_btn_req
);

  localparam logic [DB_W-1:0] c_cnt_last = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic            r_level_q;
  logic [DB_W-1:0] r_cnt;

  // The counter only runs while the synced input disagrees with the accepted
  // level, so any bounce back to the old level restarts the stability window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_q <= r_level;
      if (r_sync2 != r_level) begin
        if (r_cnt == c_cnt_last) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + DB_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_btn_req = r_level & ~r_level_q;

endmodule

`default_nettype wire

// File: rtl/effect_mode_ctrl.sv
//------------------------------------------------------------------------------
// effect_mode_ctrl : click-free effect mode sequencer; mode switches inside a
//                    sample-counted mute window. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module effect_mode_ctrl
  import audio_fx_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int          DB_W            = 16,
  parameter int unsigned MUTE_SAMPLES    = 64,
  parameter int          MS_W            = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_next,
  input  logic       i_cfg_valid,
  input  logic [1:0] i_cfg_mode,
  output logic       o_cfg_ready,
  input  logic       i_sample_strobe,
  output logic       o_effect_dist,
  output logic       o_effect_delay,
  output logic       o_effect_iir,
  output logic [1:0] o_mode,
  output logic       o_mute,
  output logic       o_busy
);

  localparam logic [MS_W-1:0] c_cnt_last = MS_W'(MUTE_SAMPLES - 1);

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_next_state;
  logic [1:0]      r_mode;
  logic [1:0]      r_target;
  logic [MS_W-1:0] r_cnt;
  logic [2:0]      r_fx;
  logic            w_btn_req;
  logic            w_cnt_done;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_W            (DB_W)
  ) u_btn_debounce (
    .clk       (clk),
    .rst       (rst),
    .i_btn     (i_btn_next),
    .o_btn_req (w_btn_req)
  );

  assign w_cnt_done = i_sample_strobe && (r_cnt == c_cnt_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A config request always wins over a same-cycle button request.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RUN: begin
        if (i_cfg_valid) begin
          if (i_cfg_mode != r_mode) w_next_state = ST_MUTE_OUT;
        end else if (w_btn_req) begin
          w_next_state = ST_MUTE_OUT;
        end
      end
      ST_MUTE_OUT: if (w_cnt_done) w_next_state = ST_MUTE_IN;
      ST_MUTE_IN:  if (w_cnt_done) w_next_state = ST_RUN;
      default:     w_next_state = ST_RUN;
    endcase
  end

  always_comb begin
    o_cfg_ready = (r_state == ST_RUN);
    o_mute      = (r_state != ST_RUN);
    o_busy      = (r_state != ST_RUN);
  end

  // Mode is only ever updated at the MUTE_OUT -> MUTE_IN boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode   <= MODE_BYPASS;
      r_target <= MODE_BYPASS;
      r_cnt    <= '0;
      r_fx     <= 3'b000;
    end else begin
      r_fx <= mode_to_fx(r_mode);
      case (r_state)
        ST_RUN: begin
          r_cnt <= '0;
          if (i_cfg_valid) begin
            if (i_cfg_mode != r_mode) r_target <= i_cfg_mode;
          end else if (w_btn_req) begin
            r_target <= r_mode + 2'd1;
          end
        end
        ST_MUTE_OUT: begin
          if (i_sample_strobe) begin
            if (r_cnt == c_cnt_last) begin
              r_cnt  <= '0;
              r_mode <= r_target;
            end else begin
              r_cnt <= r_cnt + MS_W'(1);
            end
          end
        end
        ST_MUTE_IN: begin
          if (i_sample_strobe) begin
            if (r_cnt == c_cnt_last) r_cnt <= '0;
            else                     r_cnt <= r_cnt + MS_W'(1);
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign o_effect_dist  = r_fx[0];
  assign o_effect_delay = r_fx[1];
  assign o_effect_iir   = r_fx[2];
  assign o_mode         = r_mode;

endmodule

`default_nettype wire

// File: tb/tb_effect_mode_ctrl.sv
//------------------------------------------------------------------------------
// tb_effect_mode_ctrl : directed self-checking bench for effect_mode_ctrl
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_effect_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_mode = 2'd0;
  logic       strobe = 1'b0;
  logic       strobe_en = 1'b0;
  logic       cfg_ready, e_dist, e_delay, e_iir, mute, busy;
  logic [1:0] mode;
  logic [2:0] fx;

  int n_cmp = 0;
  int n_err = 0;

  assign fx = {e_iir, e_delay, e_dist};

  always #5 clk = ~clk;

  effect_mode_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .DB_W            (16),
    .MUTE_SAMPLES    (4),
    .MS_W            (7)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .i_btn_next      (btn),
    .i_cfg_valid     (cfg_valid),
    .i_cfg_mode      (cfg_mode),
    .o_cfg_ready     (cfg_ready),
    .i_sample_strobe (strobe),
    .o_effect_dist   (e_dist),
    .o_effect_delay  (e_delay),
    .o_effect_iir    (e_iir),
    .o_mode          (mode),
    .o_mute          (mute),
    .o_busy          (busy)
  );

  // One-cycle strobe every 8 clocks while enabled.
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #2;
      k = (k == 7) ? 0 : k + 1;
      strobe = strobe_en && (k == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_fx(input logic [1:0] m);
    case (m)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic wait_strobes(input int n);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < 200) begin
      @(posedge clk);
      cyc++;
      if (strobe) seen++;
    end
    if (seen < n) check("strobe_timeout", seen, n);
  endtask

  task automatic wait_mute(input logic v);
    int cyc = 0;
    while (mute !== v && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("mute_wait", mute, v);
  endtask

  task automatic press(input bit bouncy);
    @(negedge clk);
    if (bouncy) begin
      for (int i = 0; i < 12; i++) begin
        btn = ((i / 2) % 2 == 0);
        @(negedge clk);
      end
    end
    btn = 1'b1;
    repeat (10) @(negedge clk);
    btn = 1'b0;
  endtask

  // Called right after MUTE_OUT is entered, with strobes enabled.
  task automatic transition(input logic [1:0] from_m, input logic [1:0] to_m);
    wait_strobes(4);
    @(negedge clk);
    check("mode_swap", mode, to_m);
    check("mute_mid", mute, 1);
    check("fx_lag", fx, exp_fx(from_m));
    @(negedge clk);
    check("fx_new", fx, exp_fx(to_m));
    check("busy_mid", busy, 1);
    wait_strobes(4);
    @(negedge clk);
    check("mute_end", mute, 0);
    check("busy_end", busy, 0);
    check("ready_end", cfg_ready, 1);
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mode", mode, 0);
    check("rst_fx", fx, 3'b000);
    check("rst_mute", mute, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cfg_ready, 1);

    // Clean press: 0 -> 1, nothing moves until strobes arrive
    press(0);
    wait_mute(1);
    check("press_busy", busy, 1);
    check("press_ready", cfg_ready, 0);
    check("press_mode_hold", mode, 0);
    strobe_en = 1'b1;
    transition(2'd0, 2'd1);

    // Bouncy press: exactly one advance 1 -> 2
    strobe_en = 1'b0;
    press(1);
    wait_mute(1);
    strobe_en = 1'b1;
    transition(2'd1, 2'd2);
    repeat (20) @(negedge clk);
    check("bounce_single", mute, 0);
    check("bounce_mode", mode, 2);

    // 2 -> 3, then wrap 3 -> 0
    strobe_en = 1'b0;
    press(0);
    wait_mute(1);
    strobe_en = 1'b1;
    transition(2'd2, 2'd3);
    strobe_en = 1'b0;
    press(0);
    wait_mute(1);
    strobe_en = 1'b1;
    transition(2'd3, 2'd0);

    // Config and button request in the same cycle: config wins
    strobe_en = 1'b0;
    @(negedge clk);
    btn = 1'b1;
    cyc = 0;
    while (!u_dut.w_btn_req && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("req_seen", u_dut.w_btn_req, 1);
    cfg_valid = 1'b1;
    cfg_mode  = 2'd3;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("both_mute", mute, 1);
    repeat (4) @(negedge clk);
    btn = 1'b0;
    strobe_en = 1'b1;
    transition(2'd0, 2'd3);
    repeat (30) @(negedge clk);
    check("btn_dropped", mute, 0);
    check("both_mode", mode, 3);

    // Config accepted in RUN on the same cycle
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_mode  = 2'd2;
    #1 check("cfg_ready_run", cfg_ready, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    check("cfg_mute", mute, 1);
    transition(2'd3, 2'd2);

    // Same-mode request: no mute window
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_mode  = 2'd2;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("noop_mute", mute, 0);
    repeat (5) @(negedge clk);
    check("noop_mute_late", mute, 0);
    check("noop_mode", mode, 2);

    // Request held off during mute, accepted once back in RUN
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_mode  = 2'd1;
    @(negedge clk);
    check("hold_mute", mute, 1);
    cfg_mode = 2'd3;
    #1 check("hold_ready", cfg_ready, 0);
    transition(2'd2, 2'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
    check("held_accept", mute, 1);
    transition(2'd1, 2'd3);

    // Strobe stall in MUTE_OUT
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_mode  = 2'd1;
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_strobes(2);
    strobe_en = 1'b0;
    repeat (200) @(negedge clk);
    check("stall_mode", mode, 3);
    check("stall_mute", mute, 1);
    check("stall_busy", busy, 1);
    strobe_en = 1'b1;
    wait_strobes(2);
    @(negedge clk);
    check("resume_mode", mode, 1);
    wait_strobes(4);
    @(negedge clk);
    check("resume_mute", mute, 0);

    // Asynchronous reset in the middle of MUTE_IN
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_mode  = 2'd2;
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_strobes(4);
    @(negedge clk);
    check("pre_rst_mode", mode, 2);
    wait_strobes(1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_mode", mode, 0);
    check("arst_fx", fx, 3'b000);
    check("arst_mute", mute, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", cfg_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_mute", mute, 0);
    check("post_rst_mode", mode, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
